seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for an NUM_DIGITS-digit common-segment 7-segment display.
//  Accepts a packed hex word plus per-digit decimal-point/blank flags via valid/ready,
//  double-buffers it, and scans digits with dead-time. Adds leading-zero suppression.
//  Sits between datapath/debug registers and the board display pins.
// PARAMETERS
//  NUM_DIGITS     4     digits scanned; digit 0 = least significant, scanned first
//  SCAN_DIV       1000  clk cycles each digit is lit per visit (>=1)
//  BLANK_CYCLES   2     all-off dead-time cycles before each digit (>=1)
//  SEG_ACTIVE_LOW 0     1: seg/dp pins lit when 0
//  DIG_ACTIVE_LOW 1     1: digit_en pins lit when 0
// PORTS
//  clk          in   1              clock
//  reset        in   1              asynchronous, active-low reset
//  enable       in   1              1 = scanning; 0 = display dark
//  lz_suppress  in   1              1 = blank leading zeros
//  load_valid   in   1              load request
//  load_ready   out  1              pending buffer empty
//  load_hex     in   4*NUM_DIGITS   nibble i -> digit i
//  load_dp      in   NUM_DIGITS     decimal point per digit
//  load_blank   in   NUM_DIGITS     force digit dark
//  seg          out  7              {a,b,c,d,e,f,g} = seg[6:0]
//  dp           out  1              decimal point pin
//  digit_en     out  NUM_DIGITS     one-hot (in lit polarity) digit select
//  frame_done   out  1              1-cycle pulse at end of last digit's SHOW
// BEHAVIOUR
//  Reset: seg/dp/digit_en at unlit level; load_ready=1; frame_done=0; active display
//   regs: all load_blank=1, hex=0, dp=0; pending empty; FSM=BLANK, digit index 0, counters 0.
//  All outputs registered. "Lit" means polarity-applied per *_ACTIVE_LOW.
//  FSM: BLANK (all dark, BLANK_CYCLES cycles) -> SHOW (digit idx lit, SCAN_DIV cycles)
//   -> BLANK with idx+1; after idx=NUM_DIGITS-1, idx wraps to 0. One frame =
//   NUM_DIGITS*(BLANK_CYCLES+SCAN_DIV) cycles; never two digit_en bits lit at once.
//  Segment decode: 0-F standard hex glyphs (0=1111110, 1=0110000, A=1110111,
//   b=0011111, C=1001110, d=0111101, E=1001111, F=1000111), bit6=a.
//  Digit dark (seg unlit, digit_en still lit for timing) if blank flag set or suppressed.
//  LZ suppression: scanning from digit NUM_DIGITS-1 down, a digit is suppressed while
//   its value=0, its dp=0 and every more-significant digit is suppressed/blank-0; digit 0
//   is never suppressed. dp pin follows dp flag even on blanked digits.
//  Handshake: load accepted when load_valid&&load_ready -> pending buffer, load_ready=0
//   next cycle. Pending copied to active regs only at frame boundary (cycle frame_done
//   asserts) -> no tearing; load_ready=1 next cycle. Load accepted in the boundary cycle
//   itself waits for the next boundary. load_valid while !load_ready: ignored, no stall.
//  enable=0: next cycle all pins unlit, FSM->BLANK idx 0, counters 0, no frame_done;
//   pending (if any) copied to active immediately. enable 0->1 starts fresh frame.
//  lz_suppress/enable sampled every cycle; LZ change takes effect on next digit SHOW.
//  Reset asserted mid-frame: outputs unlit immediately (async), all state to reset values.
//  Counter widths $clog2(max(SCAN_DIV,BLANK_CYCLES)+1); idx width $clog2(NUM_DIGITS), min 1.
// STRUCTURE
//  Package seg7_pkg: segment bit index constants (SEG_A=6..SEG_G=0), hex_to_seg()
//   glyph function, scan state enum {S_BLANK, S_SHOW}.
//  Sub-module seg7_hex_decoder (comb, 4->7 via hex_to_seg); one instance on selected nibble.
//  Top holds FSM, counters, pending/active buffers, LZ mask logic, output polarity flops.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1)
//  Reset release, no load -> digit_en cycles 1110,1101,1011,0111 each 4 cycles after
//   1 all-1111 cycle; seg=0000000 throughout; frame_done every 20 cycles.
//  Load hex=16'h12AF, blank=0 -> after next frame_done: digit0 seg=1000111, digit1
//   1110111, digit2 1101101, digit3 0110000; load_ready low until that boundary.
//  Load hex=16'h0042, lz_suppress=1 -> digits 3,2 seg=0000000; digit1 0110011,
//   digit0 1101101; with load_dp=4'b0100 digit2 shows 1111110 and dp=1.
//  Load hex=16'h0000, lz=1 -> only digit0 lit 1111110; second load while pending ->
//   ignored (load_ready=0), first value displayed.
//  enable=0 mid-SHOW of digit2 -> next cycle digit_en=1111, seg=0; re-enable -> digit0
//   after 1 blank cycle; pending applied during disable.
//  reset low mid-frame -> outputs unlit same cycle, load_ready=1, active regs blank.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment bit positions,
// the hex glyph table and the scan FSM state encoding.
package seg7_pkg;

    // Bit positions inside a 7-bit segment word {a,b,c,d,e,f,g}
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_e;

    // Standard hex glyphs, 1 = segment lit, bit 6 = segment a
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] g;
        g = 7'b0000000;
        case (hex)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            4'hF: g = 7'b1000111;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit hex to 7-segment glyph decoder (active-high segments).
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    logic [6:0] glyph;

    // Look up the glyph for the incoming nibble
    always_comb begin
        glyph = hex_to_seg(hex);
    end

    // Pin order is {a,b,c,d,e,f,g}; spelled out so a board remap is a one-line change
    assign seg = {glyph[SEG_A], glyph[SEG_B], glyph[SEG_C], glyph[SEG_D],
                  glyph[SEG_E], glyph[SEG_F], glyph[SEG_G]};

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with a double-buffered load
// port, dead-time between digits and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    lz_suppress,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_hex,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic [NUM_DIGITS-1:0]   load_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    // Scan FSM
    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_end;   // last cycle of last digit's SHOW
    logic             show_start;  // last BLANK cycle, SHOW begins next

    // Pending (load side) and active (display side) buffers
    logic                    pend_valid_q;
    logic [4*NUM_DIGITS-1:0] pend_hex_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic [NUM_DIGITS-1:0]   pend_blank_q;
    logic [4*NUM_DIGITS-1:0] act_hex_q;
    logic [NUM_DIGITS-1:0]   act_dp_q;
    logic [NUM_DIGITS-1:0]   act_blank_q;

    // Digit selection and leading-zero mask
    logic [NUM_DIGITS-1:0] sup;
    logic                  chain;
    logic [3:0]            sel_hex;
    logic                  sel_dp;
    logic                  sel_dark;
    logic [6:0]            glyph;

    // Segment pattern frozen for the digit currently being shown
    logic [6:0] cur_seg_q;
    logic       cur_dp_q;

    // Active-high view of the pins for the next cycle
    logic                  lit;
    logic [6:0]            seg_lit;
    logic                  dp_lit;
    logic [NUM_DIGITS-1:0] dig_lit;

    // Scan FSM state register
    // NOTE: every clocked block uses non-blocking (<=) assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Scan FSM next state: BLANK dead-time, then SHOW, then advance to the next digit
    // NOTE: defaults assigned first so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        frame_end  = 1'b0;
        show_start = 1'b0;
        if (!enable) begin
            state_d = S_BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d    = S_SHOW;
                        cnt_d      = '0;
                        show_start = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_BLANK;
            endcase
        end
    end

    // Double buffer: accept into pending, publish to active at frame end or while dark
    // NOTE: the buffers are reset explicitly because the display must come up blank, not with garbage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid_q <= 1'b0;
            pend_hex_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            act_hex_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
        end else if (pend_valid_q && (frame_end || !enable)) begin
            act_hex_q    <= pend_hex_q;
            act_dp_q     <= pend_dp_q;
            act_blank_q  <= pend_blank_q;
            pend_valid_q <= 1'b0;
        end else if (load_valid && !pend_valid_q) begin
            pend_hex_q   <= load_hex;
            pend_dp_q    <= load_dp;
            pend_blank_q <= load_blank;
            pend_valid_q <= 1'b1;
        end
    end

    assign load_ready = !pend_valid_q;

    // Leading-zero mask: walk down from the top digit while digits stay zero with no dp
    always_comb begin
        sup   = '0;
        chain = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            sup[i] = lz_suppress && chain && (act_hex_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
            chain  = sup[i] || (chain && act_blank_q[i] && !act_dp_q[i]);
        end
    end

    // Pick the nibble and flags of the digit the scan is pointing at
    always_comb begin
        sel_hex  = 4'h0;
        sel_dp   = 1'b0;
        sel_dark = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_hex  = act_hex_q[4*i +: 4];
                sel_dp   = act_dp_q[i];
                sel_dark = act_blank_q[i] || sup[i];
            end
        end
    end

    seg7_hex_decoder u_dec (
        .hex (sel_hex),
        .seg (glyph)
    );

    // Freeze the digit's pattern on entry to SHOW so flag changes never tear a lit digit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_seg_q <= 7'b0000000;
            cur_dp_q  <= 1'b0;
        end else if (show_start) begin
            cur_seg_q <= sel_dark ? 7'b0000000 : glyph;
            cur_dp_q  <= sel_dp;
        end
    end

    // Active-high pin image derived from the current scan state
    always_comb begin
        lit     = enable && (state_q == S_SHOW);
        seg_lit = lit ? cur_seg_q : 7'b0000000;
        dp_lit  = lit && cur_dp_q;
        dig_lit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (idx_q == IDX_W'(i))) begin
                dig_lit[i] = 1'b1;
            end
        end
    end

    // Output flops with board polarity applied
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            digit_en   <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_lit ^ SEG_OFF;
            dp         <= dp_lit ^ DP_OFF;
            digit_en   <= dig_lit ^ DIG_OFF;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed loads, a frame scoreboard
// filled by the stimulus and drained by a pin monitor at each frame_done.
module tb_seg7_scan_driver;

    localparam logic [6:0] OFF = 7'b0000000;
    localparam logic [6:0] G0  = 7'b1111110;
    localparam logic [6:0] G1  = 7'b0110000;
    localparam logic [6:0] G2  = 7'b1101101;
    localparam logic [6:0] G4  = 7'b0110011;
    localparam logic [6:0] G5  = 7'b1011011;
    localparam logic [6:0] G6  = 7'b1011111;
    localparam logic [6:0] G7  = 7'b1110000;
    localparam logic [6:0] G8  = 7'b1111111;
    localparam logic [6:0] GA  = 7'b1110111;
    localparam logic [6:0] GF  = 7'b1000111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        lz_suppress = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_hex = 16'h0000;
    logic [3:0]  load_dp = 4'b0000;
    logic [3:0]  load_blank = 4'b0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digit_en;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } frame_t;

    frame_t sb[$];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .BLANK_CYCLES   (1),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .lz_suppress (lz_suppress),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_hex    (load_hex),
        .load_dp     (load_dp),
        .load_blank  (load_blank),
        .seg         (seg),
        .dp          (dp),
        .digit_en    (digit_en),
        .frame_done  (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic frame_t mk(input logic [6:0] s3, input logic [6:0] s2,
                                  input logic [6:0] s1, input logic [6:0] s0,
                                  input logic [3:0] d);
        frame_t f;
        f.seg[3] = s3;
        f.seg[2] = s2;
        f.seg[1] = s1;
        f.seg[0] = s0;
        f.dp     = d;
        return f;
    endfunction

    // Wait for the next frame_done pulse; optionally confirm load_ready stays low until then
    task automatic wait_fd(input bit chk_ready);
        bit hit;
        bit early;
        hit   = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (frame_done) hit = 1'b1;
            else if (chk_ready && load_ready) early = 1'b1;
        end
        check("frame_done_seen", 32'(hit), 32'd1);
        if (chk_ready) begin
            check("ready_held_low", 32'(early), 32'd0);
            check("ready_after_swap", 32'(load_ready), 32'd1);
        end
    endtask

    task automatic wait_digit(input logic [3:0] pat);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (digit_en == pat) hit = 1'b1;
        end
        check("digit_reached", 32'(hit), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
        load_hex   = h;
        load_dp    = d;
        load_blank = b;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check("ready_drops", 32'(load_ready), 32'd0);
    endtask

    // Monitor: collect each lit digit's pins, compare a whole frame at frame_done
    initial begin : monitor
        logic [3:0][6:0] got_seg;
        logic [3:0]      got_dp;
        frame_t          e;
        got_seg = 'x;
        got_dp  = 'x;
        forever begin
            @(negedge clk);
            check("one_hot", ($countones(~digit_en) <= 1) ? 32'd1 : 32'd0, 32'd1);
            if (!reset || !enable) begin
                got_seg = 'x;
                got_dp  = 'x;
            end else begin
                for (int d = 0; d < 4; d++) begin
                    if (!digit_en[d]) begin
                        got_seg[d] = seg;
                        got_dp[d]  = dp;
                    end
                end
                if (frame_done) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        for (int d = 0; d < 4; d++) begin
                            check($sformatf("frame_seg%0d", d), 32'(got_seg[d]), 32'(e.seg[d]));
                            check($sformatf("frame_dp%0d", d), 32'(got_dp[d]), 32'(e.dp[d]));
                        end
                    end
                    got_seg = 'x;
                    got_dp  = 'x;
                end
            end
        end
    end

    // Stimulus
    initial begin : stim
        int         c;
        logic [3:0] one;
        logic [3:0] exp_en;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_digit_en", 32'(digit_en), 32'hF);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_ready", 32'(load_ready), 32'h1);
        check("rst_frame_done", 32'(frame_done), 32'h0);

        // Scan timing with no load: blank display, 20-cycle frames
        sb.push_back(mk(OFF, OFF, OFF, OFF, 4'b0000));
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            c = k % 20;
            one = 4'b0001 << (c / 5);
            exp_en = (c % 5 == 0) ? 4'hF : ~one;
            check("scan_digit_en", 32'(digit_en), 32'(exp_en));
            check("scan_frame_done", 32'(frame_done), (c == 19) ? 32'd1 : 32'd0);
            check("scan_seg", 32'(seg), 32'h0);
        end

        // Plain hex load
        do_load(16'h12AF, 4'b0000, 4'b0000);
        wait_fd(1'b1);
        @(negedge clk);
        sb.push_back(mk(G1, G2, GA, GF, 4'b0000));

        // Leading-zero suppression, then a dp that stops it
        lz_suppress = 1'b1;
        do_load(16'h0042, 4'b0000, 4'b0000);
        wait_fd(1'b1);
        @(negedge clk);
        sb.push_back(mk(OFF, OFF, G4, G2, 4'b0000));

        do_load(16'h0042, 4'b0100, 4'b0000);
        wait_fd(1'b1);
        @(negedge clk);
        sb.push_back(mk(OFF, G0, G4, G2, 4'b0100));

        // All zero keeps digit 0; a second load while pending is dropped
        do_load(16'h0000, 4'b0000, 4'b0000);
        load_hex   = 16'h8888;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check("ready_still_low", 32'(load_ready), 32'd0);
        wait_fd(1'b1);
        @(negedge clk);
        sb.push_back(mk(OFF, OFF, OFF, G0, 4'b0000));
        sb.push_back(mk(OFF, OFF, OFF, G0, 4'b0000));
        wait_fd(1'b0);
        wait_fd(1'b0);

        // Disable during digit 2, load while dark, re-enable
        wait_digit(4'b1011);
        enable     = 1'b0;
        load_hex   = 16'h5678;
        load_dp    = 4'b1001;
        load_blank = 4'b0000;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check("dis_digit_en", 32'(digit_en), 32'hF);
        check("dis_seg", 32'(seg), 32'h0);
        check("dis_dp", 32'(dp), 32'h0);
        check("dis_frame_done", 32'(frame_done), 32'h0);
        check("dis_ready_low", 32'(load_ready), 32'h0);
        @(negedge clk);
        check("dis_ready_swap", 32'(load_ready), 32'h1);
        check("dis_digit_en2", 32'(digit_en), 32'hF);
        repeat (2) @(negedge clk);
        sb.push_back(mk(G5, G6, G7, G8, 4'b1001));
        enable = 1'b1;
        @(negedge clk);
        check("reen_blank", 32'(digit_en), 32'hF);
        @(negedge clk);
        check("reen_digit0", 32'(digit_en), 32'hE);
        check("reen_seg", 32'(seg), 32'(G8));
        check("reen_dp", 32'(dp), 32'h1);
        wait_fd(1'b0);

        // Asynchronous reset mid-frame with a load pending
        do_load(16'h1111, 4'b0000, 4'b0000);
        wait_digit(4'b1101);
        #2 reset = 1'b0;
        #1;
        check("arst_digit_en", 32'(digit_en), 32'hF);
        check("arst_seg", 32'(seg), 32'h0);
        check("arst_dp", 32'(dp), 32'h0);
        check("arst_ready", 32'(load_ready), 32'h1);
        check("arst_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        sb.push_back(mk(OFF, OFF, OFF, OFF, 4'b0000));
        wait_fd(1'b0);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
